// File: rtl/mmu_paged_if.sv
// CPU-side bundle of the paged MMU: translation request/response, fault commit,
// invalidate request and the fault/entry register port.
interface mmu_paged_if #(
    parameter int RV = 16,
    parameter int VA = RV,
    parameter int PA = RV
);
    logic              mmu_enable;
    logic              supmode;
    logic              mmu_d_proxy;
    logic              is_pc;
    logic              is_read;
    logic              is_write;
    logic [VA-1:RV/16] pcv;
    logic [VA-1:RV/16] addrv;
    logic [PA-1:RV/16] pcp;
    logic [PA-1:RV/16] addrp;
    logic              mmu_miss_fault;
    logic              mmu_prot_fault;
    logic              mmu_fault;
    logic [3:0]        inv_mmu;
    logic              inv_busy;
    logic              reg_write;
    logic              reg_sel;
    logic [RV-1:0]     reg_data;
    logic [RV-1:0]     reg_read;

    modport slave (
        input  mmu_enable, supmode, mmu_d_proxy, is_pc, is_read, is_write,
        input  pcv, addrv, mmu_fault, inv_mmu, reg_write, reg_sel, reg_data,
        output pcp, addrp, mmu_miss_fault, mmu_prot_fault, inv_busy, reg_read
    );

    modport master (
        output mmu_enable, supmode, mmu_d_proxy, is_pc, is_read, is_write,
        output pcv, addrv, mmu_fault, inv_mmu, reg_write, reg_sel, reg_data,
        input  pcp, addrp, mmu_miss_fault, mmu_prot_fault, inv_busy, reg_read
    );
endinterface

// File: rtl/mmu_paged.sv
// Paged MMU with per-privilege I/D maps, accessed/dirty tracking, readable entries
// and a sequenced invalidate sweep. Translation is combinational in the access cycle.
module mmu_paged #(
    parameter int RV          = 16,
    parameter int VA          = RV,
    parameter int PA          = RV,
    parameter int NMMU        = 8,
    parameter int DIRTY_FAULT = 0
) (
    input logic        clk,
    input logic        reset_n,
    mmu_paged_if.slave bus
);
    localparam int   P           = $clog2(NMMU);
    localparam int   UNT         = VA - P;
    localparam int   PW          = PA - UNT;
    localparam int   LO          = RV / 16;
    localparam int   NE          = 2 * NMMU;
    localparam int   TOPW        = (PW > P) ? PW : P;
    localparam logic DIRTY_CHECK = (DIRTY_FAULT != 0);

    typedef enum logic {IDLE, SWEEP} sweep_state_e;

    sweep_state_e          state_q, state_d;
    logic [P-1:0]          sweepCnt_q, sweepCnt_d;
    logic [3:0]            pending_q, pending_d;
    logic [P-1:0]          faultPtr_q, faultPtr_d;
    logic                  faultType_q, faultType_d;
    logic                  faultSup_q, faultSup_d;
    logic                  faultIns_q, faultIns_d;
    logic [NE-1:0][PW-1:0] ppnI_q, ppnI_d;
    logic [NE-1:0][PW-1:0] ppnD_q, ppnD_d;
    logic [NE-1:0]         validI_q, validI_d;
    logic [NE-1:0]         accI_q, accI_d;
    logic [NE-1:0]         validD_q, validD_d;
    logic [NE-1:0]         accD_q, accD_d;
    logic [NE-1:0]         wrD_q, wrD_d;
    logic [NE-1:0]         dirtyD_q, dirtyD_d;

    logic [P-1:0]  pgI, pgD;
    logic [P:0]    selI, selD, entIdx, sweepLo, sweepHi;
    logic [NE-1:0] validIEff, validDEff;
    logic          hitI, hitD, dataAcc, fetchMiss, dataMiss, protRaw, missAny;
    logic [RV-1:0] regRead;
    logic          unusedBits;

    assign pgI     = bus.pcv[VA-1:UNT];
    assign pgD     = bus.addrv[VA-1:UNT];
    assign selI    = {bus.supmode, pgI};
    assign selD    = {bus.supmode & ~bus.mmu_d_proxy, pgD};
    assign entIdx  = {faultSup_q, faultPtr_q};
    assign sweepLo = {1'b0, sweepCnt_q};
    assign sweepHi = {1'b1, sweepCnt_q};

    // Groups still awaiting the sweep already read as invalid: {si,sd,ui,ud}.
    assign validIEff = validI_q & ~{{NMMU{pending_q[3]}}, {NMMU{pending_q[1]}}};
    assign validDEff = validD_q & ~{{NMMU{pending_q[2]}}, {NMMU{pending_q[0]}}};

    assign hitI      = validIEff[selI];
    assign hitD      = validDEff[selD];
    assign dataAcc   = bus.is_read | bus.is_write;
    assign fetchMiss = bus.mmu_enable & bus.is_pc & ~hitI;
    assign dataMiss  = bus.mmu_enable & dataAcc & ~hitD;
    assign protRaw   = bus.mmu_enable & bus.is_write & hitD
                       & (~wrD_q[selD] | (DIRTY_CHECK & ~dirtyD_q[selD]));
    assign missAny   = fetchMiss | dataMiss;

    assign bus.mmu_miss_fault = missAny;
    assign bus.mmu_prot_fault = protRaw & ~missAny;
    assign bus.inv_busy       = (state_q == SWEEP);

    assign bus.pcp   = bus.mmu_enable ? {ppnI_q[selI], bus.pcv[UNT-1:LO]}
                                      : {PW'(pgI), bus.pcv[UNT-1:LO]};
    assign bus.addrp = bus.mmu_enable ? {ppnD_q[selD], bus.addrv[UNT-1:LO]}
                                      : {PW'(pgD), bus.addrv[UNT-1:LO]};

    always_comb begin
        regRead = '0;
        if (!bus.reg_sel) begin
            regRead[RV-1 -: P] = faultPtr_q;
            regRead[3]         = faultIns_q;
            regRead[2]         = faultSup_q;
            regRead[1]         = faultType_q;
        end else if (faultIns_q) begin
            regRead[RV-1 -: PW] = ppnI_q[entIdx];
            regRead[3]          = accI_q[entIdx];
            regRead[1]          = validI_q[entIdx];
        end else begin
            regRead[RV-1 -: PW] = ppnD_q[entIdx];
            regRead[4]          = dirtyD_q[entIdx];
            regRead[3]          = accD_q[entIdx];
            regRead[2]          = wrD_q[entIdx];
            regRead[1]          = validD_q[entIdx];
        end
    end

    assign bus.reg_read = regRead;
    assign unusedBits   = ^{bus.reg_data[RV-TOPW-1:4], bus.reg_data[0]};

    // Later assignments win: tracking < register port < sweep clear < new request.
    always_comb begin
        state_d     = state_q;
        sweepCnt_d  = sweepCnt_q;
        pending_d   = pending_q;
        faultPtr_d  = faultPtr_q;
        faultType_d = faultType_q;
        faultSup_d  = faultSup_q;
        faultIns_d  = faultIns_q;
        ppnI_d      = ppnI_q;
        ppnD_d      = ppnD_q;
        validI_d    = validI_q;
        accI_d      = accI_q;
        validD_d    = validD_q;
        accD_d      = accD_q;
        wrD_d       = wrD_q;
        dirtyD_d    = dirtyD_q;

        if (bus.mmu_enable && !bus.mmu_fault) begin
            if (bus.is_pc && hitI) begin
                accI_d[selI] = 1'b1;
            end
            if (dataAcc && hitD && !protRaw) begin
                accD_d[selD] = 1'b1;
                if (bus.is_write && !DIRTY_CHECK) begin
                    dirtyD_d[selD] = 1'b1;
                end
            end
        end

        if (bus.mmu_fault) begin
            faultPtr_d  = fetchMiss ? pgI : pgD;
            faultIns_d  = bus.is_pc;
            faultSup_d  = fetchMiss ? selI[P] : selD[P];
            faultType_d = missAny;
        end else if (bus.reg_write) begin
            if (!bus.reg_sel) begin
                faultPtr_d  = bus.reg_data[RV-1 -: P];
                faultIns_d  = bus.reg_data[3];
                faultSup_d  = bus.reg_data[2];
                faultType_d = bus.reg_data[1];
            end else if (state_q != SWEEP) begin
                if (faultIns_q) begin
                    ppnI_d[entIdx]   = bus.reg_data[RV-1 -: PW];
                    validI_d[entIdx] = bus.reg_data[1];
                    accI_d[entIdx]   = 1'b0;
                end else begin
                    ppnD_d[entIdx]   = bus.reg_data[RV-1 -: PW];
                    validD_d[entIdx] = bus.reg_data[1];
                    wrD_d[entIdx]    = bus.reg_data[2];
                    accD_d[entIdx]   = 1'b0;
                    dirtyD_d[entIdx] = 1'b0;
                end
                faultPtr_d = faultPtr_q + P'(1);
            end
        end

        if (state_q == SWEEP) begin
            if (pending_q[0]) begin
                validD_d[sweepLo] = 1'b0;
                accD_d[sweepLo]   = 1'b0;
                dirtyD_d[sweepLo] = 1'b0;
            end
            if (pending_q[1]) begin
                validI_d[sweepLo] = 1'b0;
                accI_d[sweepLo]   = 1'b0;
            end
            if (pending_q[2]) begin
                validD_d[sweepHi] = 1'b0;
                accD_d[sweepHi]   = 1'b0;
                dirtyD_d[sweepHi] = 1'b0;
            end
            if (pending_q[3]) begin
                validI_d[sweepHi] = 1'b0;
                accI_d[sweepHi]   = 1'b0;
            end
            if (sweepCnt_q == P'(NMMU - 1)) begin
                state_d   = IDLE;
                pending_d = '0;
            end else begin
                sweepCnt_d = sweepCnt_q + P'(1);
            end
        end

        if (bus.inv_mmu != 4'b0000) begin
            pending_d  = pending_q | bus.inv_mmu;
            sweepCnt_d = '0;
            state_d    = SWEEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sweepCnt_q  <= '0;
            pending_q   <= '0;
            faultPtr_q  <= '0;
            faultType_q <= 1'b0;
            faultSup_q  <= 1'b0;
            faultIns_q  <= 1'b0;
            ppnI_q      <= '0;
            ppnD_q      <= '0;
            validI_q    <= '0;
            accI_q      <= '0;
            validD_q    <= '0;
            accD_q      <= '0;
            wrD_q       <= '0;
            dirtyD_q    <= '0;
        end else begin
            state_q     <= state_d;
            sweepCnt_q  <= sweepCnt_d;
            pending_q   <= pending_d;
            faultPtr_q  <= faultPtr_d;
            faultType_q <= faultType_d;
            faultSup_q  <= faultSup_d;
            faultIns_q  <= faultIns_d;
            ppnI_q      <= ppnI_d;
            ppnD_q      <= ppnD_d;
            validI_q    <= validI_d;
            accI_q      <= accI_d;
            validD_q    <= validD_d;
            accD_q      <= accD_d;
            wrD_q       <= wrD_d;
            dirtyD_q    <= dirtyD_d;
        end
    end
endmodule

// File: tb/tb_mmu_paged.sv
// Directed bench for mmu_paged: a translation vector table plus hand-written
// sequences for fault capture, entry access, invalidate sweeps and reset.
module tb_mmu_paged;
    localparam int RV   = 16;
    localparam int VA   = 16;
    localparam int PA   = 16;
    localparam int NMMU = 8;

    typedef struct {
        string       name;
        logic        enable;
        logic        sup;
        logic        proxy;
        logic        pc;
        logic        rd;
        logic        wr;
        logic [14:0] pcv;
        logic [14:0] addrv;
        logic [14:0] expPcp;
        logic [14:0] expAddrp;
        logic        expMiss;
        logic        expProt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int          testsRun = 0;
    int          testsFailed = 0;
    int          busyCycles;
    logic [15:0] rdata;
    vec_t        vecs[12];

    always #5 clk = ~clk;

    mmu_paged_if #(.RV(RV), .VA(VA), .PA(PA)) ifA ();
    mmu_paged_if #(.RV(RV), .VA(VA), .PA(PA)) ifB ();

    mmu_paged #(.RV(RV), .VA(VA), .PA(PA), .NMMU(NMMU), .DIRTY_FAULT(0)) dutA (
        .clk(clk), .reset_n(reset_n), .bus(ifA.slave)
    );
    mmu_paged #(.RV(RV), .VA(VA), .PA(PA), .NMMU(NMMU), .DIRTY_FAULT(1)) dutB (
        .clk(clk), .reset_n(reset_n), .bus(ifB.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleAll();
        ifA.mmu_enable = 0; ifA.supmode = 0; ifA.mmu_d_proxy = 0; ifA.is_pc = 0;
        ifA.is_read = 0; ifA.is_write = 0; ifA.pcv = '0; ifA.addrv = '0; ifA.mmu_fault = 0;
        ifA.inv_mmu = '0; ifA.reg_write = 0; ifA.reg_sel = 0; ifA.reg_data = '0;
        ifB.mmu_enable = 0; ifB.supmode = 0; ifB.mmu_d_proxy = 0; ifB.is_pc = 0;
        ifB.is_read = 0; ifB.is_write = 0; ifB.pcv = '0; ifB.addrv = '0; ifB.mmu_fault = 0;
        ifB.inv_mmu = '0; ifB.reg_write = 0; ifB.reg_sel = 0; ifB.reg_data = '0;
    endtask

    task automatic regWrite(input bit useB, input logic sel, input logic [15:0] data);
        if (useB) begin
            ifB.reg_sel = sel; ifB.reg_data = data; ifB.reg_write = 1;
            tick();
            ifB.reg_write = 0;
        end else begin
            ifA.reg_sel = sel; ifA.reg_data = data; ifA.reg_write = 1;
            tick();
            ifA.reg_write = 0;
        end
    endtask

    task automatic readReg(input bit useB, input logic sel, output logic [15:0] data);
        if (useB) begin
            ifB.reg_sel = sel;
            #1;
            data = ifB.reg_read;
        end else begin
            ifA.reg_sel = sel;
            #1;
            data = ifA.reg_read;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ifA.mmu_enable = v.enable; ifA.supmode = v.sup; ifA.mmu_d_proxy = v.proxy;
        ifA.is_pc = v.pc; ifA.is_read = v.rd; ifA.is_write = v.wr;
        ifA.pcv = v.pcv; ifA.addrv = v.addrv;
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // name, en, sup, proxy, pc, rd, wr, pcv, addrv, pcp, addrp, miss, prot
        vecs[0]  = '{"dis_fetch",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15'h1234, 15'h0000, 15'h1234, 15'h0000, 1'b0, 1'b0};
        vecs[1]  = '{"dis_write",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0000, 15'h7FFF, 15'h0000, 15'h7FFF, 1'b0, 1'b0};
        vecs[2]  = '{"rd_hit",     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h2040, 15'h0000, 15'h5040, 1'b0, 1'b0};
        vecs[3]  = '{"wr_prot",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0000, 15'h3123, 15'h0000, 15'h1123, 1'b0, 1'b1};
        vecs[4]  = '{"rd_ro",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h3123, 15'h0000, 15'h1123, 1'b0, 1'b0};
        vecs[5]  = '{"rd_miss",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h4000, 15'h0000, 15'h0000, 1'b1, 1'b0};
        vecs[6]  = '{"sup_miss",   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h2040, 15'h0000, 15'h0040, 1'b1, 1'b0};
        vecs[7]  = '{"proxy_hit",  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 15'h0000, 15'h2040, 15'h0000, 15'h5040, 1'b0, 1'b0};
        vecs[8]  = '{"fetch_miss", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15'h2000, 15'h0000, 15'h0000, 15'h0000, 1'b1, 1'b0};
        vecs[9]  = '{"no_access",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0000, 15'h4000, 15'h0000, 15'h0000, 1'b0, 1'b0};
        vecs[10] = '{"miss_prio",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 15'h0000, 15'h3000, 15'h0000, 15'h1000, 1'b1, 1'b0};
        vecs[11] = '{"wr_hit",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0000, 15'h2FFE, 15'h0000, 15'h5FFE, 1'b0, 1'b0};

        idleAll();
        reset_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", ifA.inv_busy, 0);
        checkOutput("rst_busy_b", ifB.inv_busy, 0);
        checkOutput("rst_miss", ifA.mmu_miss_fault, 0);
        readReg(0, 0, rdata); checkOutput("rst_fault_reg", rdata, 16'h0000);
        readReg(0, 1, rdata); checkOutput("rst_entry_reg", rdata, 16'h0000);
        reset_n = 1'b1;
        tick();

        // Fetch miss on an empty map, committed by the core
        ifA.mmu_enable = 1; ifA.is_pc = 1; ifA.pcv = 15'h1234;
        #1;
        checkOutput("first_fetch_miss", ifA.mmu_miss_fault, 1);
        ifA.mmu_fault = 1;
        tick();
        ifA.mmu_fault = 0; ifA.is_pc = 0; ifA.pcv = '0;
        readReg(0, 0, rdata); checkOutput("fault_capture", rdata, 16'h200A);

        // Pointer load, entry write with pointer advance, write hit sets A and D
        regWrite(0, 0, 16'h4000);
        readReg(0, 0, rdata); checkOutput("ptr_load", rdata, 16'h4000);
        regWrite(0, 1, 16'hA006);
        readReg(0, 0, rdata); checkOutput("ptr_advance", rdata, 16'h6000);
        ifA.is_write = 1; ifA.addrv = 15'h2040;
        #1;
        checkOutput("wr_addrp", ifA.addrp, 15'h5040);
        checkOutput("wr_miss", ifA.mmu_miss_fault, 0);
        checkOutput("wr_prot", ifA.mmu_prot_fault, 0);
        tick();
        ifA.is_write = 0;
        regWrite(0, 0, 16'h4000);
        readReg(0, 1, rdata); checkOutput("entry_ad_set", rdata, 16'hA01E);

        // Write-protected page: prot fault committed, D untouched
        regWrite(0, 0, 16'h6000);
        regWrite(0, 1, 16'h2002);
        ifA.is_write = 1; ifA.addrv = 15'h3000;
        #1;
        checkOutput("ro_prot", ifA.mmu_prot_fault, 1);
        checkOutput("ro_miss", ifA.mmu_miss_fault, 0);
        ifA.mmu_fault = 1;
        tick();
        ifA.mmu_fault = 0; ifA.is_write = 0; ifA.addrv = '0;
        readReg(0, 0, rdata); checkOutput("prot_capture", rdata, 16'h6000);
        readReg(0, 1, rdata); checkOutput("ro_entry_clean", rdata, 16'h2002);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput({vecs[i].name, "_pcp"}, ifA.pcp, vecs[i].expPcp);
            checkOutput({vecs[i].name, "_addrp"}, ifA.addrp, vecs[i].expAddrp);
            checkOutput({vecs[i].name, "_miss"}, ifA.mmu_miss_fault, vecs[i].expMiss);
            checkOutput({vecs[i].name, "_prot"}, ifA.mmu_prot_fault, vecs[i].expProt);
        end
        ifA.supmode = 0; ifA.mmu_d_proxy = 0; ifA.is_pc = 0; ifA.is_read = 0; ifA.is_write = 0;
        ifA.mmu_enable = 1; ifA.pcv = '0; ifA.addrv = '0;

        // Fill all user-D pages (page i -> ppn 7-i) plus one supervisor-D page
        regWrite(0, 0, 16'h0000);
        for (int i = 0; i < NMMU; i++) begin
            regWrite(0, 1, 16'((7 - i) << 13) | 16'h0006);
        end
        readReg(0, 0, rdata); checkOutput("ptr_wrap", rdata, 16'h0000);
        regWrite(0, 0, 16'h0004);
        regWrite(0, 1, 16'hE002);
        ifA.is_read = 1; ifA.addrv = 15'h5000;
        #1;
        checkOutput("fill_hit", ifA.addrp, 15'h2000);
        checkOutput("fill_hit_miss", ifA.mmu_miss_fault, 0);
        ifA.is_read = 0;

        ifA.inv_mmu = 4'b0001;
        tick();
        ifA.inv_mmu = 4'b0000;
        checkOutput("sweep_busy", ifA.inv_busy, 1);
        ifA.is_read = 1; ifA.addrv = 15'h5000;
        #1;
        checkOutput("sweep_ud_miss", ifA.mmu_miss_fault, 1);
        ifA.supmode = 1; ifA.addrv = 15'h0000;
        #1;
        checkOutput("sweep_sd_addrp", ifA.addrp, 15'h7000);
        checkOutput("sweep_sd_miss", ifA.mmu_miss_fault, 0);
        ifA.supmode = 0; ifA.is_read = 0;
        busyCycles = 0;
        while (ifA.inv_busy && busyCycles < 40) begin
            busyCycles++;
            tick();
        end
        checkOutput("sweep_len", busyCycles, 8);
        checkOutput("sweep_done", ifA.inv_busy, 0);
        regWrite(0, 0, 16'h0000);
        readReg(0, 1, rdata); checkOutput("swept_ud_entry", rdata, 16'hE004);
        regWrite(0, 0, 16'h0004);
        readReg(0, 1, rdata); checkOutput("kept_sd_entry", rdata, 16'hE002);

        // Second request during the sweep restarts the count
        ifA.inv_mmu = 4'b0001;
        tick();
        ifA.inv_mmu = 4'b0000;
        busyCycles = 0;
        while (ifA.inv_busy && busyCycles < 40) begin
            busyCycles++;
            ifA.inv_mmu = (busyCycles == 3) ? 4'b0100 : 4'b0000;
            tick();
        end
        ifA.inv_mmu = 4'b0000;
        checkOutput("restart_len", busyCycles, 11);
        readReg(0, 1, rdata); checkOutput("swept_sd_entry", rdata, 16'hE000);

        // Reset in the middle of a sweep
        regWrite(0, 0, 16'h0000);
        ifA.inv_mmu = 4'b0001;
        tick();
        ifA.inv_mmu = 4'b0000;
        checkOutput("abort_busy_pre", ifA.inv_busy, 1);
        tick();
        reset_n = 1'b0;
        tick();
        checkOutput("abort_busy", ifA.inv_busy, 0);
        readReg(0, 0, rdata); checkOutput("abort_fault_reg", rdata, 16'h0000);
        regWrite(0, 0, 16'h0000);
        readReg(0, 1, rdata); checkOutput("abort_entry_reg", rdata, 16'h0000);
        reset_n = 1'b1;
        tick();

        // Clean-page fault variant: W=1,D=0 write faults, read only sets A
        regWrite(1, 0, 16'h2000);
        regWrite(1, 1, 16'h6006);
        ifB.mmu_enable = 1; ifB.is_write = 1; ifB.addrv = 15'h1000;
        #1;
        checkOutput("df_wr_prot", ifB.mmu_prot_fault, 1);
        checkOutput("df_wr_miss", ifB.mmu_miss_fault, 0);
        checkOutput("df_wr_addrp", ifB.addrp, 15'h3000);
        tick();
        ifB.is_write = 0; ifB.is_read = 1;
        #1;
        checkOutput("df_rd_prot", ifB.mmu_prot_fault, 0);
        checkOutput("df_rd_miss", ifB.mmu_miss_fault, 0);
        tick();
        ifB.is_read = 0;
        regWrite(1, 0, 16'h2000);
        readReg(1, 1, rdata); checkOutput("df_entry_a_only", rdata, 16'h600E);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
